// File: rtl/l2c_pkg.sv
// Shared L2C definitions: way count, epoch width, epoch-controller FSM
// states and the modulo-8 epoch arithmetic helper.
package l2c_pkg;

  localparam int L2C_WAYS  = 8;
  localparam int L2C_EPC_W = 3;

  typedef logic [L2C_EPC_W-1:0] epc_t;

  // Scrub-and-advance sequencing states of the epoch controller.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_ADV  = 3'd4
  } epc_state_e;

  // Epoch addition that wraps naturally at the 3-bit boundary (7 + 1 = 0).
  function automatic epc_t epc_add(input epc_t e, input epc_t n);
    return e + n;
  endfunction

endpackage

// File: rtl/l2c_epc_timer.sv
// Epoch period timer: counts down while enabled and emits a one-cycle
// advance request each time the count reaches 1, reloading from the period.
module l2c_epc_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PER_W-1:0] period,
  output logic             req
);

  logic [PER_W-1:0] cnt;
  logic             run;
  logic             at_one;

  // A zero period disables the timer just like a low enable; a count that
  // somehow sits at 0 is treated like the terminal count so it cannot stall.
  assign run    = en && (period != '0);
  assign at_one = (cnt <= PER_W'(1));
  assign req    = run && at_one;

  // Countdown register; holds its value whenever the timer is not running.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= period;
    end else if (run) begin
      if (at_one) begin
        cnt <= period;
      end else begin
        cnt <= cnt - PER_W'(1);
      end
    end
  end

endmodule

// File: rtl/l2c_epc_ctl.sv
// L2C epoch controller. Before each epoch advance it walks every set,
// reads the tags and rewrites any valid, non-transient way stamped with
// cur+2 back to cur, so that stamp cannot alias the new "next" epoch
// after the 3-bit wrap. Then it bumps the epoch seen by the policy.
module l2c_epc_ctl
  import l2c_pkg::*;
#(
  parameter int SET_W = 9,
  parameter int PER_W = 16
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          i_epoch_en,
  input  logic [PER_W-1:0]              i_epoch_period,
  input  logic                          i_sw_advance,
  output logic [L2C_EPC_W-1:0]          o_ctl_epoch,
  output logic                          o_scrub_busy,
  output logic                          o_epoch_overrun,
  input  logic                          i_clr_overrun,
  output logic                          o_scr_req,
  output logic [SET_W-1:0]              o_scr_set,
  input  logic                          i_scr_gnt,
  input  logic                          i_scr_rd_vld,
  input  logic [L2C_WAYS-1:0]           i_scr_tag_V,
  input  logic [L2C_WAYS-1:0]           i_scr_tag_transient,
  input  logic [L2C_WAYS*L2C_EPC_W-1:0] i_scr_tag_epc,
  output logic                          o_scr_wr_vld,
  output logic [L2C_WAYS-1:0]           o_scr_wr_mask,
  output logic [L2C_EPC_W-1:0]          o_scr_wr_epc,
  input  logic                          i_scr_wr_ack
);

  epc_state_e          state, state_n;
  logic [SET_W-1:0]    set_q, set_n;
  logic [L2C_WAYS-1:0] mask_q, mask_n;
  epc_t                epoch_q, epoch_n;
  logic                pend_q, pend_n;
  logic                overrun_q, overrun_n;

  logic                tmr_req;
  logic                new_req;
  logic                last_set;
  logic [L2C_WAYS-1:0] match;
  epc_t                stale_epc;

  l2c_epc_timer #(
    .PER_W (PER_W)
  ) u_timer (
    .clk    (Clk),
    .reset  (Reset),
    .en     (i_epoch_en),
    .period (i_epoch_period),
    .req    (tmr_req)
  );

  assign new_req   = tmr_req | i_sw_advance;
  assign last_set  = (set_q == {SET_W{1'b1}});
  assign stale_epc = epc_add(epoch_q, epc_t'(2));

  // Ways that would alias the upcoming "next" epoch once the epoch advances;
  // transient ways are left alone because the fill path restamps them.
  always_comb begin
    match = '0;
    for (int w = 0; w < L2C_WAYS; w++) begin
      match[w] = i_scr_tag_V[w] & ~i_scr_tag_transient[w] &
                 (i_scr_tag_epc[L2C_EPC_W*w +: L2C_EPC_W] == stale_epc);
    end
  end

  // Next-state logic: a request in IDLE starts a scrub at once, otherwise
  // it is remembered in the pending flag for the scrub after this one.
  always_comb begin
    state_n = state;
    set_n   = set_q;
    mask_n  = mask_q;
    epoch_n = epoch_q;
    pend_n  = pend_q;
    if (new_req) begin
      pend_n = 1'b1;
    end
    case (state)
      ST_IDLE: begin
        if (pend_q || new_req) begin
          state_n = ST_REQ;
          set_n   = '0;
          pend_n  = 1'b0;
        end
      end
      ST_REQ: begin
        if (i_scr_gnt) begin
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_scr_rd_vld) begin
          if (match != '0) begin
            state_n = ST_WR;
            mask_n  = match;
          end else if (last_set) begin
            state_n = ST_ADV;
          end else begin
            state_n = ST_REQ;
            set_n   = set_q + SET_W'(1);
          end
        end
      end
      ST_WR: begin
        if (i_scr_wr_ack) begin
          mask_n = '0;
          if (last_set) begin
            state_n = ST_ADV;
          end else begin
            state_n = ST_REQ;
            set_n   = set_q + SET_W'(1);
          end
        end
      end
      ST_ADV: begin
        epoch_n = epc_add(epoch_q, epc_t'(1));
        set_n   = '0;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Overrun is sticky until software clears it; a clear beats a new overrun.
  always_comb begin
    overrun_n = overrun_q | (new_req & pend_q);
    if (i_clr_overrun) begin
      overrun_n = 1'b0;
    end
  end

  // State and datapath registers; reset abandons any scrub in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      set_q     <= '0;
      mask_q    <= '0;
      epoch_q   <= '0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_n;
      set_q     <= set_n;
      mask_q    <= mask_n;
      epoch_q   <= epoch_n;
      pend_q    <= pend_n;
      overrun_q <= overrun_n;
    end
  end

  assign o_ctl_epoch     = epoch_q;
  assign o_scrub_busy    = (state != ST_IDLE);
  assign o_epoch_overrun = overrun_q;
  assign o_scr_req       = (state == ST_REQ);
  assign o_scr_set       = set_q;
  assign o_scr_wr_vld    = (state == ST_WR);
  assign o_scr_wr_mask   = mask_q;
  assign o_scr_wr_epc    = (state == ST_WR) ? epoch_q : '0;

endmodule
